// File: rtl/kitchen_pkg.sv
// Shared types and constants for the UART transmit-side command path.
package kitchen_pkg;
  localparam int unsigned UART_WIDTH = 8;
  localparam logic [UART_WIDTH-1:0] IDLE_BYTE_DEFAULT = 8'h00;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;
endpackage

// File: rtl/uart_tx_queue_if.sv
// Command-producer / UART-side signal bundle for uart_tx_queue.
interface uart_tx_queue_if #(
  parameter int unsigned DEPTH = 8
);
  import kitchen_pkg::*;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  push_valid;
  logic [UART_WIDTH-1:0] push_data;
  logic                  push_ready;
  logic                  flush;
  logic                  tx_ready;
  logic [UART_WIDTH-1:0] tx_bits;
  logic [CW-1:0]         count;
  logic                  busy;
  logic                  overflow;

  modport master (
    output push_valid, push_data, flush, tx_ready,
    input  push_ready, tx_bits, count, busy, overflow
  );

  modport slave (
    input  push_valid, push_data, flush, tx_ready,
    output push_ready, tx_bits, count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and clear.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        cnt <= cnt + CW'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// Transmit command queue: bytes change on tx_bits only at UART frame edges,
// each held for REPEAT frames, with IDLE_BYTE shown when nothing is in flight.
module uart_tx_queue
  import kitchen_pkg::*;
#(
  parameter int unsigned           DEPTH     = 8,
  parameter int unsigned           REPEAT    = 1,
  parameter logic [UART_WIDTH-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  uart_tx_queue_if.slave  q
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  tx_state_t             state;
  logic [UART_WIDTH-1:0] tx_bits_r;
  logic [RW-1:0]         rep_cnt;
  logic                  overflow_r;
  logic                  ready_d;

  logic                  frame_edge;
  logic                  last_rep;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [UART_WIDTH-1:0] head;
  logic [CW-1:0]         fifo_count;

  assign frame_edge = q.tx_ready && !ready_d;
  assign last_rep   = (rep_cnt == RW'(REPEAT - 1));
  assign fifo_push  = q.push_valid && !q.flush;
  // Pop only when the edge actually loads a new byte; flush suppresses it.
  assign fifo_pop   = frame_edge && !q.flush && !fifo_empty &&
                      ((state == IDLE) || last_rep);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (q.flush),
    .wr_data (q.push_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx_bits_r  <= IDLE_BYTE;
      rep_cnt    <= '0;
      overflow_r <= 1'b0;
      ready_d    <= 1'b0;
    end else begin
      ready_d <= q.tx_ready;
      if (q.flush) begin
        state      <= IDLE;
        tx_bits_r  <= IDLE_BYTE;
        rep_cnt    <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (q.push_valid && fifo_full)
          overflow_r <= 1'b1;
        if (frame_edge) begin
          case (state)
            IDLE: begin
              if (!fifo_empty) begin
                tx_bits_r <= head;
                rep_cnt   <= '0;
                state     <= SEND;
              end
            end
            SEND: begin
              if (!last_rep) begin
                rep_cnt <= rep_cnt + RW'(1);
              end else if (!fifo_empty) begin
                tx_bits_r <= head;
                rep_cnt   <= '0;
              end else begin
                tx_bits_r <= IDLE_BYTE;
                state     <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign q.tx_bits    = tx_bits_r;
  assign q.count      = fifo_count;
  assign q.push_ready = !fifo_full;
  assign q.busy       = (state == SEND) || (fifo_count != '0);
  assign q.overflow   = overflow_r;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed checks of uart_tx_queue: a vector table plus multi-cycle sequences.
module tb_uart_tx_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(8)) q1 ();
  uart_tx_queue_if #(.DEPTH(8)) q2 ();

  uart_tx_queue #(.DEPTH(8), .REPEAT(1), .IDLE_BYTE(8'h00)) dut1 (
    .clk (clk),
    .rst (rst),
    .q   (q1)
  );

  uart_tx_queue #(.DEPTH(8), .REPEAT(2), .IDLE_BYTE(8'h00)) dut2 (
    .clk (clk),
    .rst (rst),
    .q   (q2)
  );

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       fl;
    logic       tr;
    logic [7:0] e_tx;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_ovf;
    logic       e_pr;
  } vec_t;

  vec_t vq[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic add(input logic pv, input logic [7:0] pd, input logic fl,
                     input logic tr, input logic [7:0] tx, input logic [7:0] cnt,
                     input logic busy, input logic ovf, input logic pr);
    vec_t v;
    v = '{pv, pd, fl, tr, tx, cnt, busy, ovf, pr};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic pv, input logic [7:0] pd, input logic fl, input logic tr);
    q1.push_valid = pv;
    q1.push_data  = pd;
    q1.flush      = fl;
    q1.tx_ready   = tr;
  endtask

  task automatic chk_all1(input string tag, input logic [7:0] tx, input logic [7:0] cnt,
                          input logic busy, input logic ovf, input logic pr);
    chk({tag, ".tx_bits"},    q1.tx_bits, tx);
    chk({tag, ".count"},      8'(q1.count), cnt);
    chk({tag, ".busy"},       8'(q1.busy), 8'(busy));
    chk({tag, ".overflow"},   8'(q1.overflow), 8'(ovf));
    chk({tag, ".push_ready"}, 8'(q1.push_ready), 8'(pr));
  endtask

  initial begin
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    q2.push_valid = 1'b0;
    q2.push_data  = 8'h00;
    q2.flush      = 1'b0;
    q2.tx_ready   = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk_all1("reset", 8'h00, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("reset2.tx_bits", q2.tx_bits, 8'h00);

    //  pv  pd     fl  tr  tx     cnt busy ovf pr
    add(1, 8'h45, 0, 0, 8'h00, 1, 1, 0, 1);   // push while IDLE
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);   // edge loads
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);   // next edge -> idle
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 8'h45, 0, 0, 8'h00, 1, 1, 0, 1);   // level held 5 cycles
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h45, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 8'h66, 0, 1, 8'h00, 1, 1, 0, 1);   // push on edge into empty FIFO
    add(0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h66, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h66, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 8'h11, 0, 0, 8'h00, 1, 1, 0, 1);
    add(1, 8'h22, 0, 0, 8'h00, 2, 1, 0, 1);
    add(1, 8'h33, 0, 1, 8'h11, 2, 1, 0, 1);   // simultaneous push and pop
    add(0, 8'h00, 0, 0, 8'h11, 2, 1, 0, 1);
    add(1, 8'h77, 1, 1, 8'h00, 0, 0, 0, 1);   // flush beats push and edge
    add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);

    foreach (vq[i]) begin
      drive1(vq[i].pv, vq[i].pd, vq[i].fl, vq[i].tr);
      step();
      chk_all1($sformatf("vec%0d", i), vq[i].e_tx, vq[i].e_cnt,
               vq[i].e_busy, vq[i].e_ovf, vq[i].e_pr);
    end
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Fill to capacity, then overflow.
    for (int i = 1; i <= 8; i++) begin
      drive1(1'b1, 8'(i), 1'b0, 1'b0);
      step();
      chk($sformatf("fill%0d.count", i), 8'(q1.count), 8'(i));
    end
    drive1(1'b1, 8'h09, 1'b0, 1'b0);
    step();
    chk_all1("full_push", 8'h00, 8'd8, 1'b1, 1'b1, 1'b0);

    // Pop from full with concurrent push: push still dropped.
    drive1(1'b1, 8'hAA, 1'b0, 1'b1);
    step();
    chk_all1("full_pop_push", 8'h01, 8'd7, 1'b1, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    for (int i = 2; i <= 8; i++) begin
      drive1(1'b0, 8'h00, 1'b0, 1'b1);
      step();
      chk($sformatf("drain%0d.tx_bits", i), q1.tx_bits, 8'(i));
      drive1(1'b0, 8'h00, 1'b0, 1'b0);
      step();
    end
    drive1(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk_all1("drained", 8'h00, 8'd0, 1'b0, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("flush_clears.overflow", 8'(q1.overflow), 8'h00);
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Reset in the middle of traffic.
    for (int i = 0; i < 9; i++) begin
      drive1(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step();
    end
    drive1(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("pre_reset.tx_bits", q1.tx_bits, 8'h80);
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    step();
    step();
    chk_all1("mid_reset", 8'h00, 8'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    drive1(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk_all1("post_reset_edge", 8'h00, 8'd0, 1'b0, 1'b0, 1'b1);
    drive1(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // REPEAT=2 instance: each byte held for two frames.
    q2.push_valid = 1'b1;
    q2.push_data  = 8'h12;
    step();
    q2.push_data  = 8'h34;
    step();
    q2.push_valid = 1'b0;
    chk("rep2.count", 8'(q2.count), 8'd2);
    begin
      logic [7:0] exp_seq [5];
      exp_seq = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h00};
      for (int i = 0; i < 5; i++) begin
        q2.tx_ready = 1'b1;
        step();
        chk($sformatf("rep2_edge%0d.tx_bits", i), q2.tx_bits, exp_seq[i]);
        q2.tx_ready = 1'b0;
        step();
      end
    end
    chk("rep2_end.busy", 8'(q2.busy), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
